// File: rtl/fsm_6s2i2o_step_ctrl.sv
// Step controller for the 6-state, 2-input, 2-output Moore FSM. It owns the state register
// and steps it once per accepted symbol. Optional idle timeout: define FSM_STEP_CTRL_TIMEOUT_EN.
module fsm_6s2i2o_step_ctrl #(
  parameter int CNT_W = 8
`ifdef FSM_STEP_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [1:0]       in_msg,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [4:0]       out_msg,
  output logic [2:0]       cur_state,
  output logic [CNT_W-1:0] d_count
`ifdef FSM_STEP_CTRL_TIMEOUT_EN
  , output logic           timeout_flag
`endif
);

  typedef enum logic [2:0] {
    S_A = 3'd0, S_B = 3'd1, S_C = 3'd2, S_D = 3'd3, S_E = 3'd4, S_F = 3'd5
  } state_t;

  // Handshake: a transfer happens on a rising edge where valid && ready; a raised valid holds
  // its payload stable until accepted. One output register, so in_rdy = !out_val || out_rdy.

  function automatic logic [2:0] next_state(input logic [2:0] s, input logic [1:0] i);
    logic [2:0] n;
    n = S_A;
    case (s)
      S_A: n = (i == 2'b01) ? S_B : (i == 2'b11) ? S_E : S_A;
      S_B: n = (i == 2'b00) ? S_C : (i == 2'b01) ? S_B : (i == 2'b11) ? S_E : S_A;
      S_C: n = (i == 2'b01) ? S_D : (i == 2'b11) ? S_E : S_A;
      S_D: n = (i == 2'b00) ? S_C : (i == 2'b01) ? S_B : (i == 2'b11) ? S_E : S_A;
      S_E: n = (i[1] == 1'b0) ? S_F : (i == 2'b11) ? S_E : S_A;
      default: n = S_A;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] moore_out(input logic [2:0] s);
    logic [1:0] o;
    o = 2'b00;
    case (s)
      S_D:      o = 2'b01;
      S_E, S_F: o = 2'b10;
      default:  o = 2'b00;
    endcase
    return o;
  endfunction

  logic [2:0]       state_q, state_d, ns;
  logic             out_val_q, out_val_d;
  logic [4:0]       out_msg_q, out_msg_d;
  logic [CNT_W-1:0] d_count_q, d_count_d;
  logic             step;

`ifdef FSM_STEP_CTRL_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              flag_q, flag_d;
`endif

  always_comb begin
    in_rdy    = reset && !restart && (!out_val_q || out_rdy);
    step      = in_val && in_rdy;
    ns        = next_state(state_q, in_msg);
    state_d   = state_q;
    out_val_d = out_val_q;
    out_msg_d = out_msg_q;
    d_count_d = d_count_q;
`ifdef FSM_STEP_CTRL_TIMEOUT_EN
    idle_d    = idle_q;
    flag_d    = flag_q;
`endif
    if (restart) begin
      state_d   = S_A;
      out_val_d = 1'b0;
`ifdef FSM_STEP_CTRL_TIMEOUT_EN
      idle_d    = '0;
`endif
    end else begin
      if (step) begin
        state_d   = ns;
        out_val_d = 1'b1;
        out_msg_d = {ns, moore_out(ns)};
        if (ns == S_D && d_count_q != {CNT_W{1'b1}}) d_count_d = d_count_q + 1'b1;
      end else if (out_val_q && out_rdy) begin
        out_val_d = 1'b0;
      end
`ifdef FSM_STEP_CTRL_TIMEOUT_EN
      // The timeout only forces the state home; it never emits a result.
      if (step || state_q == S_A) begin
        idle_d = '0;
      end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
        idle_d  = '0;
        state_d = S_A;
        flag_d  = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_A;
      out_val_q <= 1'b0;
      out_msg_q <= '0;
      d_count_q <= '0;
`ifdef FSM_STEP_CTRL_TIMEOUT_EN
      idle_q    <= '0;
      flag_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      out_val_q <= out_val_d;
      out_msg_q <= out_msg_d;
      d_count_q <= d_count_d;
`ifdef FSM_STEP_CTRL_TIMEOUT_EN
      idle_q    <= idle_d;
      flag_q    <= flag_d;
`endif
    end
  end

  assign out_val   = out_val_q;
  assign out_msg   = out_msg_q;
  assign cur_state = state_q;
  assign d_count   = d_count_q;
`ifdef FSM_STEP_CTRL_TIMEOUT_EN
  assign timeout_flag = flag_q;
`endif

endmodule
